seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Consumer of the processor's 16-bit register display word. Drives a 4-digit
//   common-anode seven-segment display in hex, one digit at a time.
//   Latches the display word only at frame boundaries so the display never tears.
//   Blanks leading zeros and flashes digit 0's decimal point when the value changes.
//   Runs on the board clock, the same clock that feeds the processor's clock divider.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (>=2); 1 kHz/digit at 100 MHz
//   BLANK_LZ     1       1: blank leading zeros on digits 3..1; 0: show all digits
//   CHG_HOLD     50      frames the change-indicator dp stays lit (>=1)
// PORTS
//   clk    in   1   board clock
//   rst    in   1   asynchronous, active-low reset
//   value  in   16  display word from the register bank; same clock domain, no synchroniser
//   en     in   1   display enable; 0 blanks all outputs
//   an     out  4   digit anodes, active-low; an[0] is the rightmost digit, value[3:0]
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1   decimal point, active-low
// BEHAVIOUR
//   Reset (rst=0, async, immediate):
//     cnt=0, idx=3, shown=0, chg_cnt=0, an=4'hF, seg=7'h7F, dp=1.
//   Refresh counter:
//     cnt counts 0..REFRESH_DIV-1 and wraps.
//     tick=1 on the cycle where cnt==REFRESH_DIV-1.
//   On a tick:
//     idx <= idx+1 mod 4.
//     If idx==3, a frame boundary occurs: shown <= value.
//       If value!=shown, chg_cnt <= CHG_HOLD.
//       Otherwise, if chg_cnt!=0, chg_cnt <= chg_cnt-1.
//   Outputs:
//     Registered, and updated on the same edge as idx/shown.
//     They reflect the new idx and the new shown value.
//     Between ticks the outputs hold.
//     The first digit (idx 0) appears REFRESH_DIV cycles after reset release.
//   Anode: an = ~(4'b0001 << idx).
//   Decode of nibble n = shown[4*idx+3 : 4*idx], mapping 0..F to:
//     40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex, active-low).
//   Leading-zero blank:
//     If BLANK_LZ=1, idx!=0 and shown[15:4*idx]==0, then seg=7'h7F.
//     The anode is still driven in that case.
//     Digit 0 is never blanked.
//   Decimal point: dp=0 only when idx==0 and chg_cnt!=0; otherwise dp=1.
//   Enable:
//     en=0 sampled at an edge: an=4'hF, seg=7'h7F, dp=1 from that edge.
//     While en=0, cnt/idx/shown/chg_cnt keep running.
//     When en returns to 1, the outputs show the current idx on the next edge.
//     They do not wait for a tick.
//   Simultaneous events:
//     A value change that is not at a frame boundary is invisible until the next frame.
//     A change at the boundary reloads chg_cnt even when chg_cnt is nonzero.
//   Reset mid-frame: everything returns to the reset values at once.
//     The scan restarts from idx=3.
// TESTING (REFRESH_DIV=4, CHG_HOLD=2, BLANK_LZ=1 unless stated)
//   1. rst=0 -> an=F seg=7F dp=1.
//      Release with value=16'h1234, en=1 -> 4th edge: an=1110 seg=19.
//      Then every 4 clks: an 1101/seg 30, an 1011/seg 24, an 0111/seg 79, back to 1110/19.
//   2. value=16'h0005 -> digits 3..1: anode low, seg=7F; digit 0: seg=12.
//      value=0 -> digit 0 seg=40.
//      With BLANK_LZ=0 and value=0 -> every digit seg=40.
//   3. Tear-free: shown=1234; switch value to ABCD while idx=1.
//      -> digits 2,3 still show 24,79.
//      -> next frame shows 21,46,03,08.
//   4. Value change latched -> dp=0 during idx 0 for exactly 2 frames, then dp=1.
//      Unchanged value -> dp stays 1.
//   5. en=0 mid-scan at idx=2 -> next edge an=F seg=7F.
//      en=1 one tick later -> next edge an=0111 (idx advanced to 3), correct segments.
//   6. Assert rst between clock edges mid-frame -> an=F seg=7F dp=1 with no clk edge.
//      After release, the first tick shows digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver for a common-anode seven-segment module.
// The display word is captured only at frame boundaries, so a frame never mixes two words.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1,
  parameter int CHG_HOLD    = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int CHG_W = (CHG_HOLD > 1) ? $clog2(CHG_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CHG_W-1:0] CHG_LOAD = CHG_W'(CHG_HOLD);

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic [15:0]      shown_r, shown_nxt_s;
  logic [CHG_W-1:0] chg_cnt_r, chg_nxt_s;
  logic [3:0]       an_r, an_nxt_s;
  logic [6:0]       seg_r, seg_nxt_s;
  logic             dp_r, dp_nxt_s;
  logic             tick_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'h40;
      4'h1:    seg_decode = 7'h79;
      4'h2:    seg_decode = 7'h24;
      4'h3:    seg_decode = 7'h30;
      4'h4:    seg_decode = 7'h19;
      4'h5:    seg_decode = 7'h12;
      4'h6:    seg_decode = 7'h02;
      4'h7:    seg_decode = 7'h78;
      4'h8:    seg_decode = 7'h00;
      4'h9:    seg_decode = 7'h10;
      4'hA:    seg_decode = 7'h08;
      4'hB:    seg_decode = 7'h03;
      4'hC:    seg_decode = 7'h46;
      4'hD:    seg_decode = 7'h21;
      4'hE:    seg_decode = 7'h06;
      4'hF:    seg_decode = 7'h0E;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    nibble_sel = word[3:0];
      2'd1:    nibble_sel = word[7:4];
      2'd2:    nibble_sel = word[11:8];
      2'd3:    nibble_sel = word[15:12];
      default: nibble_sel = word[3:0];
    endcase
  endfunction

  // True when this digit and every digit to its left are zero; digit 0 never qualifies.
  function automatic logic leading_zero(input logic [15:0] word, input logic [1:0] idx);
    case (idx)
      2'd1:    leading_zero = (word[15:4] == 12'h000);
      2'd2:    leading_zero = (word[15:8] == 8'h00);
      2'd3:    leading_zero = (word[15:12] == 4'h0);
      default: leading_zero = 1'b0;
    endcase
  endfunction

  assign tick_s = (cnt_r == CNT_LAST);

  // Scan position, frame capture and change-indicator countdown.
  always_comb begin
    cnt_nxt_s   = cnt_r + CNT_W'(1);
    idx_nxt_s   = idx_r;
    shown_nxt_s = shown_r;
    chg_nxt_s   = chg_cnt_r;
    if (tick_s) begin
      cnt_nxt_s = '0;
      idx_nxt_s = idx_r + 2'd1;
      if (idx_r == 2'd3) begin
        shown_nxt_s = value;
        if (value != shown_r) begin
          chg_nxt_s = CHG_LOAD;
        end else if (chg_cnt_r != '0) begin
          chg_nxt_s = chg_cnt_r - CHG_W'(1);
        end else begin
          chg_nxt_s = chg_cnt_r;
        end
      end else begin
        shown_nxt_s = shown_r;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Outputs follow the post-edge scan state, so they hold between ticks and recover immediately on enable.
  always_comb begin
    an_nxt_s  = 4'hF;
    seg_nxt_s = 7'h7F;
    dp_nxt_s  = 1'b1;
    if (en) begin
      an_nxt_s = ~(4'b0001 << idx_nxt_s);
      if ((BLANK_LZ != 0) && leading_zero(shown_nxt_s, idx_nxt_s)) begin
        seg_nxt_s = 7'h7F;
      end else begin
        seg_nxt_s = seg_decode(nibble_sel(shown_nxt_s, idx_nxt_s));
      end
      dp_nxt_s = ~((idx_nxt_s == 2'd0) && (chg_nxt_s != '0));
    end else begin
      an_nxt_s = 4'hF;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= '0;
      idx_r     <= 2'd3;
      shown_r   <= 16'h0000;
      chg_cnt_r <= '0;
      an_r      <= 4'hF;
      seg_r     <= 7'h7F;
      dp_r      <= 1'b1;
    end else begin
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      shown_r   <= shown_nxt_s;
      chg_cnt_r <= chg_nxt_s;
      an_r      <= an_nxt_s;
      seg_r     <= seg_nxt_s;
      dp_r      <= dp_nxt_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule
